slc3_datapath_gen2: RTL
=======================

// Module: slc3_datapath_gen2
// PURPOSE
//  Parametrised second-generation SLC-3 datapath: PC, IR, MAR, MDR, 8-entry regfile, ALU, NZP/BEN and LED register.
//  All are joined by a single gated bus.
//  Sits between the control FSM (drives LD_*/Gate*/mux selects) and the memory/IO subsystem.
//  New versus gen 1:
//   - width-generic;
//   - MDR memory load uses a ready handshake;
//   - bus contention is detected.
// PARAMETERS
//  W        16       datapath/bus width; instruction fields always read from IR[15:0]; W>=16
//  LED_W    12       LED register width; loaded from IR[LED_W-1:0]; LED_W<=16
//  PC_RST   'h3000   PC value after reset (truncated/zero-extended to W)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR, LD_LED   in 1 each   register load enables
//  GatePC, GateMDR, GateALU, GateMARMUX   in 1 each   bus drivers, at most one expected
//  PCMUX      in   2      0:PC+1  1:bus  2:addr-adder  3:reserved (holds PC)
//  DRMUX      in   1      0:IR[11:9]  1:R7
//  SR1MUX     in   1      0:IR[11:9]  1:IR[8:6]
//  ADDR1MUX   in   1      0:PC  1:SR1
//  ADDR2MUX   in   2      0:zero  1:sext(IR[5:0])  2:sext(IR[8:0])  3:sext(IR[10:0])
//  ALUK       in   2      0:ADD  1:AND  2:NOT A  3:PASS A
//  MIO_EN     in   1      1: MDR loads from MDR_In; 0: MDR loads from bus
//  MDR_In     in   W      memory read data
//  MEM_RDY    in   1      memory read data valid this cycle
//  BEN        out  1      registered branch enable
//  IR_OUT     out  W      instruction register
//  PC_OUT     out  W      program counter
//  MAR_OUT    out  W      memory address register
//  MDR_OUT    out  W      memory data register
//  MDR_BUSY   out  1      waiting for MEM_RDY on a memory MDR load
//  BUS_ERR    out  1      sticky: >1 gate asserted in some cycle
//  LED        out  LED_W  LED register
// BEHAVIOUR
//  Reset (reset==0, async):
//   - PC=PC_RST; IR, MAR, MDR, R0-R7 and LED = 0.
//   - NZP=3'b010; BEN=0; MDR_BUSY=0; BUS_ERR=0.
//   - Reset mid-wait abandons the pending load and clears MDR_BUSY.
//  Bus (combinational):
//   - value = the single gated source; zero when no gate or >1 gate asserted.
//   - On >1 gate asserted, BUS_ERR sets on the next edge and is cleared only by reset.
//  GateMARMUX drives the addr-adder: ADDR1MUX + ADDR2MUX, modulo 2^W.
//  ALU:
//   - A=SR1.
//   - B = IR[5] ? sext(IR[4:0]) : SR2(IR[2:0]).
//   - ADD wraps modulo 2^W.
//  Register writes, all single-cycle at the edge when the load is high:
//   - LD_REG: regfile[DRMUX sel] <= bus.
//   - LD_IR: IR <= bus.
//   - LD_MAR: MAR <= bus.
//   - LD_PC: PC <= PCMUX result (PC+1 wraps at 2^W).
//   - LD_LED: LED <= IR[LED_W-1:0].
//  Regfile reads are combinational; a same-cycle write is seen next cycle (no bypass).
//  LD_CC: NZP <= {bus[W-1], bus==0, !bus[W-1] && bus!=0}; exactly one bit set.
//  LD_BEN: BEN <= (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using NZP before any same-edge LD_CC.
//  MDR load, 2-state FSM IDLE/WAIT:
//   - IDLE, LD_MDR & !MIO_EN: MDR <= bus; stay IDLE.
//   - IDLE, LD_MDR & MIO_EN & MEM_RDY: MDR <= MDR_In; stay IDLE (zero wait).
//   - IDLE, LD_MDR & MIO_EN & !MEM_RDY: go to WAIT; MDR_BUSY=1 (combinational from state).
//   - WAIT: MDR holds. On MEM_RDY, MDR <= MDR_In and go to IDLE.
//   - LD_MDR in WAIT is ignored; the controller must hold its state while MDR_BUSY=1.
//  Other registers are unaffected by WAIT.
// STRUCTURE
//  Package slc3_gen2_pkg:
//   - enums pcmux_e, addr2mux_e, aluk_e.
//   - typedef nzp_t.
//   - constant NREGS=8.
//   - function sext().
//  One sub-module: slc3_regfile_gen2 (8xW, 2 async read ports, 1 sync write, async active-low reset).
//  ALU, muxes and the MDR FSM stay inline.
// TESTING
//  1. Reset low mid-run -> PC=0x3000, NZP=010, BEN=0, all regs 0, BUS_ERR=0, independent of clk.
//  2. R2=7, IR=0x12A5 (ADD R1,R2,#5), GateALU+LD_REG+LD_CC -> R1=0x000C, NZP=001.
//  3. IR=0x0A00 (BRnp); NZP=010 then LD_BEN -> BEN=0; NZP=100 then LD_BEN -> BEN=1.
//  4. LD_MDR+MIO_EN, MEM_RDY low 3 cycles then high with MDR_In=0xBEEF:
//     -> MDR_BUSY high exactly 3 cycles; MDR=0xBEEF the edge after; an LD_MDR pulse mid-wait has no effect.
//  5. GatePC+GateMDR same cycle -> bus=0, BUS_ERR=1 next edge, stays 1 until reset.
//  6. W=20: PC=0xFFFFF, PCMUX=0, LD_PC -> PC=0; IR=0x07FF (PCoffset=-1), GateMARMUX -> bus=PC-1 mod 2^20.

Source files
------------

// File: rtl/slc3_gen2_pkg.sv
// slc3_gen2_pkg: shared mux/ALU encodings, condition-code type, register count and sign-extension helper
package slc3_gen2_pkg;
  localparam int NREGS = 8;
  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDR, PC_HOLD} pcmux_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_e;
  typedef enum logic {MDR_IDLE, MDR_WAIT} mdr_state_e;
  typedef struct packed {logic n; logic z; logic p;} nzp_t;
  // Sign-extends the low n bits of v to 64 bits; callers size the result down to the datapath width.
  function automatic logic [63:0] sext(input logic [15:0] v, input int n);
    logic [63:0] t;
    t = {48'b0, v} << (64 - n);
    return $signed(t) >>> (64 - n);
  endfunction
endpackage

// File: rtl/slc3_regfile_gen2.sv
// slc3_regfile_gen2: 8xW register file, two combinational read ports, one synchronous write port
// Ports: clk/reset (async active-low); i_we/i_wsel/i_wdata write; i_rsel1/i_rsel2 -> o_rdata1/o_rdata2 reads.
module slc3_regfile_gen2
  import slc3_gen2_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_we,
  input  logic [2:0]   i_wsel,
  input  logic [W-1:0] i_wdata,
  input  logic [2:0]   i_rsel1,
  input  logic [2:0]   i_rsel2,
  output logic [W-1:0] o_rdata1,
  output logic [W-1:0] o_rdata2
);
  logic [W-1:0] r_regs [NREGS];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    else if (i_we) r_regs[i_wsel] <= i_wdata;
  assign o_rdata1 = r_regs[i_rsel1];
  assign o_rdata2 = r_regs[i_rsel2];
endmodule

// File: rtl/slc3_datapath_gen2.sv
// slc3_datapath_gen2: width-generic SLC-3 datapath (PC, IR, MAR, MDR, regfile, ALU, NZP/BEN, LED) on one gated bus
// Ports: clk, reset (async active-low); LD_* load enables; Gate* bus drivers; PCMUX/DRMUX/SR1MUX/ADDR1MUX/ADDR2MUX/ALUK
//        selects; MIO_EN/MDR_In/MEM_RDY memory load path; outputs BEN, IR/PC/MAR/MDR, MDR_BUSY, sticky BUS_ERR, LED.
module slc3_datapath_gen2
  import slc3_gen2_pkg::*;
#(
  parameter int          W      = 16,
  parameter int          LED_W  = 12,
  parameter logic [63:0] PC_RST = 64'h3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LD_REG,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_IR,
  input  logic             LD_PC,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_LED,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       PCMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic             MIO_EN,
  input  logic [W-1:0]     MDR_In,
  input  logic             MEM_RDY,
  output logic             BEN,
  output logic [W-1:0]     IR_OUT,
  output logic [W-1:0]     PC_OUT,
  output logic [W-1:0]     MAR_OUT,
  output logic [W-1:0]     MDR_OUT,
  output logic             MDR_BUSY,
  output logic             BUS_ERR,
  output logic [LED_W-1:0] LED
);
  logic [W-1:0] r_pc, r_ir, r_mar, r_mdr;
  logic [LED_W-1:0] r_led;
  nzp_t r_nzp, w_nzp_next;
  logic r_ben, r_bus_err, w_ben_next, w_multi;
  mdr_state_e r_state, w_state_next;
  logic [W-1:0] w_mdr_next, w_sr1, w_sr2, w_alu_b, w_alu, w_addr1, w_addr2, w_addr, w_bus, w_pc_next;
  logic [15:0] w_ir;
  logic [2:0] w_ngate, w_sr1_sel, w_dr_sel;
  pcmux_e w_pcmux;
  addr2mux_e w_addr2mux;
  aluk_e w_aluk;
  assign w_ir       = r_ir[15:0];
  assign w_pcmux    = pcmux_e'(PCMUX);
  assign w_addr2mux = addr2mux_e'(ADDR2MUX);
  assign w_aluk     = aluk_e'(ALUK);
  assign w_sr1_sel  = SR1MUX ? w_ir[8:6] : w_ir[11:9];
  assign w_dr_sel   = DRMUX ? 3'd7 : w_ir[11:9];
  slc3_regfile_gen2 #(.W(W)) u_rf (
    .clk(clk), .reset(reset), .i_we(LD_REG), .i_wsel(w_dr_sel), .i_wdata(w_bus),
    .i_rsel1(w_sr1_sel), .i_rsel2(w_ir[2:0]), .o_rdata1(w_sr1), .o_rdata2(w_sr2)
  );
  assign w_alu_b = w_ir[5] ? W'(sext(w_ir, 5)) : w_sr2;
  assign w_alu   = w_aluk == ALU_ADD ? w_sr1 + w_alu_b :
                   w_aluk == ALU_AND ? w_sr1 & w_alu_b :
                   w_aluk == ALU_NOT ? ~w_sr1 : w_sr1;
  assign w_addr1 = ADDR1MUX ? w_sr1 : r_pc;
  assign w_addr2 = w_addr2mux == A2_OFF6 ? W'(sext(w_ir, 6)) :
                   w_addr2mux == A2_OFF9 ? W'(sext(w_ir, 9)) :
                   w_addr2mux == A2_OFF11 ? W'(sext(w_ir, 11)) : '0;
  assign w_addr  = w_addr1 + w_addr2;
  // Contending gates force the bus to zero so no register captures a mix of sources.
  assign w_ngate = 3'(GatePC) + 3'(GateMDR) + 3'(GateALU) + 3'(GateMARMUX);
  assign w_multi = w_ngate > 3'd1;
  assign w_bus   = w_multi ? '0 : GatePC ? r_pc : GateMDR ? r_mdr : GateALU ? w_alu : GateMARMUX ? w_addr : '0;
  assign w_pc_next = w_pcmux == PC_INC ? r_pc + 1'b1 :
                     w_pcmux == PC_BUS ? w_bus :
                     w_pcmux == PC_ADDR ? w_addr : r_pc;
  assign w_nzp_next = nzp_t'({w_bus[W-1], w_bus == '0, !w_bus[W-1] && w_bus != '0});
  assign w_ben_next = (w_ir[11] & r_nzp.n) | (w_ir[10] & r_nzp.z) | (w_ir[9] & r_nzp.p);
  // A memory load without data ready parks in WAIT; further LD_MDR is ignored until MEM_RDY arrives.
  always_comb begin
    w_state_next = r_state;
    w_mdr_next = r_mdr;
    if (r_state == MDR_IDLE) begin
      if (LD_MDR && !MIO_EN) w_mdr_next = w_bus;
      else if (LD_MDR && MEM_RDY) w_mdr_next = MDR_In;
      else if (LD_MDR) w_state_next = MDR_WAIT;
    end else if (MEM_RDY) begin
      w_mdr_next = MDR_In;
      w_state_next = MDR_IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_pc <= W'(PC_RST);
      r_ir <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_led <= '0;
      r_nzp <= nzp_t'(3'b010);
      r_ben <= 1'b0;
      r_bus_err <= 1'b0;
      r_state <= MDR_IDLE;
    end else begin
      if (LD_PC) r_pc <= w_pc_next;
      if (LD_IR) r_ir <= w_bus;
      if (LD_MAR) r_mar <= w_bus;
      if (LD_LED) r_led <= w_ir[LED_W-1:0];
      if (LD_CC) r_nzp <= w_nzp_next;
      if (LD_BEN) r_ben <= w_ben_next;
      if (w_multi) r_bus_err <= 1'b1;
      r_mdr <= w_mdr_next;
      r_state <= w_state_next;
    end
  assign BEN      = r_ben;
  assign IR_OUT   = r_ir;
  assign PC_OUT   = r_pc;
  assign MAR_OUT  = r_mar;
  assign MDR_OUT  = r_mdr;
  assign MDR_BUSY = r_state == MDR_WAIT;
  assign BUS_ERR  = r_bus_err;
  assign LED      = r_led;
endmodule
